// File: rtl/dmac_burst_splitter.sv
// dmac_burst_splitter: splits one linear request into MAX_BYTES_PER_BURST-bounded bursts.
// Define DMAC_BURST_SPLITTER_CHECK_EN to flag and drop misaligned requests.
module dmac_burst_splitter #(
  parameter int DMA_DATA_WIDTH      = 64,
  parameter int DMA_AXI_ADDR_WIDTH  = 32,
  parameter int DMA_LENGTH_WIDTH    = 24,
  parameter int MAX_BYTES_PER_BURST = 128,
  localparam int BEAT = DMA_DATA_WIDTH / 8,
  localparam int BLW  = ($clog2(MAX_BYTES_PER_BURST / BEAT) < 1) ? 1
                      : $clog2(MAX_BYTES_PER_BURST / BEAT)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] req_address,
  input  logic [DMA_LENGTH_WIDTH-1:0]   req_length,
  input  logic                          req_last,
  output logic                          burst_valid,
  input  logic                          burst_ready,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] burst_address,
  output logic [BLW-1:0]                burst_length,
  output logic                          burst_last,
  output logic                          busy,
  output logic                          req_error
);

  localparam int AW    = DMA_AXI_ADDR_WIDTH;
  localparam int RW    = DMA_LENGTH_WIDTH + 1;
  localparam int OFFW  = $clog2(MAX_BYTES_PER_BURST);
  localparam int BEATW = $clog2(BEAT);
  localparam logic [OFFW:0] MAX_B = (OFFW+1)'(MAX_BYTES_PER_BURST);

  typedef enum logic {IDLE, SPLIT} state_e;

  // Bytes up to the next burst boundary, capped by what is left.
  function automatic logic [RW-1:0] chunk(input logic [OFFW-1:0] off,
                                          input logic [RW-1:0]   r);
    logic [RW-1:0] room;
    room = RW'(MAX_B - {1'b0, off});
    return (r < room) ? r : room;
  endfunction

  function automatic logic [BLW-1:0] beats_m1(input logic [RW-1:0] b);
    return BLW'((b >> BEATW) - RW'(1));
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          last_q, last_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          bvalid_q, bvalid_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [BLW-1:0] blen_q, blen_d;
  logic          blast_q, blast_d;
  logic [RW-1:0] rem_in;
  logic [RW-1:0] cur;
  logic [RW-1:0] nxt;
  logic          load;
  logic          bad;

  assign rem_in = {1'b0, req_length} + RW'(1);

`ifdef DMAC_BURST_SPLITTER_CHECK_EN
  logic err_q;
  logic err_d;
  assign bad = (req_address[BEATW-1:0] != '0) || (rem_in[BEATW-1:0] != '0);
  assign err_d = req_valid && req_ready_q && (state_q == IDLE) && bad;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign req_error = err_q;
`else
  assign bad = 1'b0;
  assign req_error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    last_d      = last_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    bvalid_d    = bvalid_q;
    baddr_d     = baddr_q;
    blen_d      = blen_q;
    blast_d     = blast_q;
    load        = 1'b0;
    cur         = chunk(addr_q[OFFW-1:0], rem_q);
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q && !bad) begin
          addr_d      = req_address;
          rem_d       = rem_in;
          last_d      = req_last;
          state_d     = SPLIT;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          bvalid_d    = 1'b1;
          load        = 1'b1;
        end
      end
      SPLIT: begin
        if (burst_ready) begin
          addr_d = addr_q + AW'(cur);
          rem_d  = rem_q - cur;
          if (cur == rem_q) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            bvalid_d    = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    nxt = chunk(addr_d[OFFW-1:0], rem_d);
    if (load) begin
      baddr_d = addr_d;
      blen_d  = beats_m1(nxt);
      blast_d = last_d && (nxt == rem_d);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      last_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      bvalid_q    <= 1'b0;
      baddr_q     <= '0;
      blen_q      <= '0;
      blast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      bvalid_q    <= bvalid_d;
      baddr_q     <= baddr_d;
      blen_q      <= blen_d;
      blast_q     <= blast_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign burst_valid   = bvalid_q;
  assign burst_address = baddr_q;
  assign burst_length  = blen_q;
  assign burst_last    = blast_q;

endmodule

// File: tb/tb_dmac_burst_splitter.sv
// tb_dmac_burst_splitter: directed and random requests against a burst-list model.
// Define DMAC_BURST_SPLITTER_CHECK_EN to also cover the misalignment drop.
module tb_dmac_burst_splitter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_address = '0;
  logic [23:0] req_length = '0;
  logic        req_last = 1'b0;
  logic        burst_valid;
  logic        burst_ready = 1'b0;
  logic [31:0] burst_address;
  logic [3:0]  burst_length;
  logic        burst_last;
  logic        busy;
  logic        req_error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  l;
    logic        t;
  } burst_t;

  burst_t exp_q[$];

  dmac_burst_splitter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_length(req_length),
    .req_last(req_last),
    .burst_valid(burst_valid), .burst_ready(burst_ready),
    .burst_address(burst_address), .burst_length(burst_length),
    .burst_last(burst_last), .busy(busy), .req_error(req_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected burst list: walk the request in boundary-sized pieces.
  task automatic build(input logic [31:0] a, input int unsigned len,
                       input logic last);
    longint rem;
    longint room;
    longint b;
    logic [31:0] cur;
    burst_t e;
    rem = longint'(len) + 1;
    cur = a;
    exp_q.delete();
    while (rem > 0) begin
      room = 128 - longint'(cur % 128);
      b = (rem < room) ? rem : room;
      e.a = cur;
      e.l = 4'((b / 8) - 1);
      e.t = last && (b == rem);
      exp_q.push_back(e);
      cur = cur + 32'(b);
      rem = rem - b;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [23:0] len,
                      input logic last);
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_valid", 64'(burst_valid), 64'd0);
    req_valid = 1'b1;
    req_address = a;
    req_length = len;
    req_last = last;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // stall_first >= 0 fixes the first burst's stall; -1 means random stalls.
  task automatic run_req(input logic [31:0] a, input logic [23:0] len,
                         input logic last, input int stall_first);
    int st;
    build(a, int'(len), last);
    send(a, len, last);
    foreach (exp_q[i]) begin
      if (stall_first < 0) st = $urandom_range(0, 2);
      else st = (i == 0) ? stall_first : 0;
      burst_ready = 1'b0;
      repeat (st) begin
        chk("stall_valid", 64'(burst_valid), 64'd1);
        chk("stall_addr", 64'(burst_address), 64'(exp_q[i].a));
        chk("stall_len", 64'(burst_length), 64'(exp_q[i].l));
        @(posedge clk);
        #1;
      end
      burst_ready = 1'b1;
      chk("b_valid", 64'(burst_valid), 64'd1);
      chk("b_addr", 64'(burst_address), 64'(exp_q[i].a));
      chk("b_len", 64'(burst_length), 64'(exp_q[i].l));
      chk("b_last", 64'(burst_last), 64'(exp_q[i].t));
      chk("b_req_ready", 64'(req_ready), 64'd0);
      chk("b_busy", 64'(busy), 64'd1);
      chk("b_err", 64'(req_error), 64'd0);
      @(posedge clk);
      #1;
    end
    burst_ready = 1'b0;
    chk("done_valid", 64'(burst_valid), 64'd0);
    chk("done_req_ready", 64'(req_ready), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [23:0] rl;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(burst_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(req_error), 64'd0);
    chk("rst_addr", 64'(burst_address), 64'd0);
    chk("rst_len", 64'(burst_length), 64'd0);
    chk("rst_last", 64'(burst_last), 64'd0);
    resetn = 1'b1;

    run_req(32'h1000, 24'h17F, 1'b1, 0);
    run_req(32'h1070, 24'h02F, 1'b0, 0);
    run_req(32'h0FF8, 24'h007, 1'b1, 0);
    run_req(32'h2000, 24'h0FF, 1'b0, 5);
    run_req(32'hFFFF_FFC0, 24'h0FF, 1'b1, -1);

    // Reset during the second burst of a three-burst request.
    build(32'h4000, 32'h17F, 1'b1);
    send(32'h4000, 24'h17F, 1'b1);
    burst_ready = 1'b1;
    @(posedge clk);
    #1;
    burst_ready = 1'b0;
    chk("mid_addr", 64'(burst_address), 64'(exp_q[1].a));
    resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(burst_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_addr", 64'(burst_address), 64'd0);
    #2;
    resetn = 1'b1;
    run_req(32'h3000, 24'h07F, 1'b1, 0);

    for (int n = 0; n < 25; n++) begin
      ra = $urandom() & 32'hFFFF_FFF8;
      rl = 24'($urandom_range(0, 80) * 8 + 7);
      run_req(ra, rl, 1'($urandom_range(0, 1)), -1);
    end

`ifdef DMAC_BURST_SPLITTER_CHECK_EN
    send(32'h1004, 24'h007, 1'b1);
    chk("mis_err", 64'(req_error), 64'd1);
    chk("mis_valid", 64'(burst_valid), 64'd0);
    chk("mis_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("mis_err_pulse", 64'(req_error), 64'd0);
    chk("mis_valid2", 64'(burst_valid), 64'd0);
    send(32'h1000, 24'h003, 1'b1);
    chk("mislen_err", 64'(req_error), 64'd1);
    chk("mislen_valid", 64'(burst_valid), 64'd0);
    run_req(32'h1000, 24'h00F, 1'b1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
